// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial adder datapath.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder sequenced LSB first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_s;
    logic               w_cout;
    logic               w_last;

    full_adder u_fa (
        .A    (r_a_sh[0]),
        .B    (r_b_sh[0]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    // RUN exits on the final bit; the counter stops there and never wraps
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Sequencer: state, handshake flags, operand shifters, carry and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_state <= ST_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    if (w_last) begin
                        r_cout  <= w_cout;
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_RUN && w_last) begin
            r_ovf <= r_carry ^ w_cout;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign cout  = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): stimulus pushes expectations, a monitor pops on done.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;
`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   prev_done = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: handshake invariants every cycle, scoreboard compare on each done pulse
    always @(negedge clk) begin
        if (!rst) begin
            chk("one_hot_flags", 32'(ready) + 32'(busy) + 32'(done), 32'd1);
            if (prev_done) chk("ready_after_done", 32'(ready), 32'd1);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sum",     32'(sum),  32'(e.s));
                    chk("cout",    32'(cout), 32'(e.c));
                    chk("ovf",     32'(ovf),  32'(e.o));
                    chk("latency", 32'(cyc - e.acc), 32'(W));
                end
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    // mode: 0 plain, 1 start pulses while busy/done, 2 operand churn, 3 reset mid-RUN
    task automatic op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_c,
                      input logic [W-1:0] es, input logic ec, input logic eo, input int mode);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ready; t++) @(negedge clk);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        cin   = op_c;
        if (mode != 3) begin
            e.s   = es;
            e.c   = ec;
            e.o   = OVF_EN ? eo : 1'b0;
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        for (int i = 1; i <= 40; i++) begin
            start = 1'b0;
            if (ready) begin
                ok = 1'b1;
                break;
            end
            if (mode == 1) start = (i == 2 || i == 4 || i == 6 || done);
            if (mode == 2) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
            end
            if (mode == 3 && i == 4) begin
                rst = 1'b1;
                #1;
                chk("rst_sum",   32'(sum),   32'd0);
                chk("rst_cout",  32'(cout),  32'd0);
                chk("rst_ovf",   32'(ovf),   32'd0);
                chk("rst_ready", 32'(ready), 32'd1);
                chk("rst_busy",  32'(busy),  32'd0);
                @(negedge clk);
                rst = 1'b0;
                repeat (12) @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("op_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_done",  32'(done),  32'd0);
        chk("reset_sum",   32'(sum),   32'd0);
        chk("reset_cout",  32'(cout),  32'd0);
        chk("reset_ovf",   32'(ovf),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1);
        op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 3);
        op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 0);
        op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 2);

        // Result must hold through idle cycles while inputs keep moving
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            chk("hold_sum",  32'(sum),  32'h00);
            chk("hold_cout", 32'(cout), 32'd1);
            chk("hold_ovf",  32'(ovf),  32'(OVF_EN));
        end

        op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
        op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
